// File: rtl/stonyman_adc_pkg.sv
// Shared types and default constants for the Stonyman pixel ADC stream path.
// Part widths cover the TI ADC081S101 / ADC101S101 / ADC121S101 family.
package stonyman_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRACK,
        ST_CONVERT,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int ADC081_BITS = 8;
    localparam int ADC101_BITS = 10;
    localparam int ADC121_BITS = 12;

    localparam int ADC_BITS_DEFAULT    = ADC101_BITS;
    localparam int FRAME_SCLKS_DEFAULT = 16;
    localparam int LEAD_ZEROS_DEFAULT  = 3;
    localparam int MAX_PIXELS_DEFAULT  = 112;

endpackage

// File: rtl/adc_stream_controller_if.sv
// Serial ADC pins plus the frame FIFO write port, as seen by the stream controller.
interface adc_stream_controller_if #(
    parameter int OUT_BITS = 8
);
    logic                sclk;
    logic                cs_n;
    logic                sdata;
    logic                fifo_full;
    logic                fifo_write_enable;
    logic [OUT_BITS-1:0] fifo_write_data;

    modport master (
        output sclk, cs_n, fifo_write_enable, fifo_write_data,
        input  sdata, fifo_full
    );

    modport slave (
        input  sclk, cs_n, fifo_write_enable, fifo_write_data,
        output sdata, fifo_full
    );
endinterface

// File: rtl/adc_serial_frame.sv
// One ADCxx1S101 conversion frame: drives cs_n/sclk and shifts in the result bits.
// frame_done/raw are valid in the cycle before the edge that closes the frame.
module adc_serial_frame
    import stonyman_adc_pkg::*;
#(
    parameter int ADC_BITS    = ADC_BITS_DEFAULT,
    parameter int FRAME_SCLKS = FRAME_SCLKS_DEFAULT,
    parameter int LEAD_ZEROS  = LEAD_ZEROS_DEFAULT,
    parameter int SCLK_HALF   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                sdata,
    output logic                sclk,
    output logic                cs_n,
    output logic                frame_done,
    output logic [ADC_BITS-1:0] raw
);
    localparam int HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int RISE_W = $clog2(FRAME_SCLKS + 1);

    logic              active;
    logic [HALF_W-1:0] half_cnt;
    logic [RISE_W-1:0] rise_cnt;
    logic [ADC_BITS-1:0] shift;
    logic              toggle;
    logic              rise_now;
    logic              in_result;

    assign toggle    = active && (half_cnt == HALF_W'(SCLK_HALF - 1));
    assign rise_now  = toggle && !sclk;
    // rise_cnt counts completed rises, so the upcoming rise is rise_cnt+1.
    assign in_result = (rise_cnt >= RISE_W'(LEAD_ZEROS)) &&
                       (rise_cnt <  RISE_W'(LEAD_ZEROS + ADC_BITS));
    assign frame_done = rise_now && (rise_cnt == RISE_W'(FRAME_SCLKS - 1));
    assign raw = (rise_now && in_result) ? {shift[ADC_BITS-2:0], sdata} : shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active   <= 1'b0;
            half_cnt <= '0;
            rise_cnt <= '0;
            shift    <= '0;
            sclk     <= 1'b1;
            cs_n     <= 1'b1;
        end else if (!active) begin
            if (start) begin
                active   <= 1'b1;
                cs_n     <= 1'b0;
                half_cnt <= '0;
                rise_cnt <= '0;
                shift    <= '0;
            end
        end else if (toggle) begin
            half_cnt <= '0;
            sclk     <= ~sclk;
            if (rise_now) begin
                rise_cnt <= RISE_W'(rise_cnt + 1'b1);
                shift    <= raw;
                if (frame_done) begin
                    active <= 1'b0;
                    cs_n   <= 1'b1;
                end
            end
        end else begin
            half_cnt <= HALF_W'(half_cnt + 1'b1);
        end
    end
endmodule

// File: rtl/adc_stream_controller.sv
// Capture sequencer: per pixel track, convert, offset/scale, then write one FIFO word.
// Holds the FSM, latched configuration and the pixel counter.
module adc_stream_controller
    import stonyman_adc_pkg::*;
#(
    parameter int  ADC_BITS    = ADC_BITS_DEFAULT,
    parameter int  OUT_BITS    = 8,
    parameter int  FRAME_SCLKS = FRAME_SCLKS_DEFAULT,
    parameter int  LEAD_ZEROS  = LEAD_ZEROS_DEFAULT,
    parameter int  SCLK_HALF   = 1,
    parameter int  MAX_PIXELS  = MAX_PIXELS_DEFAULT,
    localparam int PIX_W       = $clog2(MAX_PIXELS + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 capture_start,
    input  logic [PIX_W-1:0]     pixel_count,
    input  logic [ADC_BITS-1:0]  val_offset,
    input  logic [7:0]           track_counts,
    input  logic                 scale_mode,
    output logic                 pixel_advance,
    output logic                 capture_done,
    output logic                 busy,
    adc_stream_controller_if.master bus
);
    state_t              state;
    logic [PIX_W-1:0]    cfg_count;
    logic [ADC_BITS-1:0] cfg_offset;
    logic [7:0]          cfg_track;
    logic                cfg_shift;
    logic [7:0]          track_cnt;
    logic [PIX_W-1:0]    pix_done;
    logic                write_enable;
    logic [OUT_BITS-1:0] write_data;

    logic                frame_start;
    logic                frame_done;
    logic [ADC_BITS-1:0] raw;
    logic [ADC_BITS-1:0] diff;
    logic [OUT_BITS-1:0] reduced;
    logic                sclk_int;
    logic                cs_n_int;

    assign frame_start = (state == ST_TRACK) && (track_cnt == '0);

    adc_serial_frame #(
        .ADC_BITS   (ADC_BITS),
        .FRAME_SCLKS(FRAME_SCLKS),
        .LEAD_ZEROS (LEAD_ZEROS),
        .SCLK_HALF  (SCLK_HALF)
    ) u_frame (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (frame_start),
        .sdata     (bus.sdata),
        .sclk      (sclk_int),
        .cs_n      (cs_n_int),
        .frame_done(frame_done),
        .raw       (raw)
    );

    assign bus.sclk              = sclk_int;
    assign bus.cs_n              = cs_n_int;
    assign bus.fifo_write_enable = write_enable;
    assign bus.fifo_write_data   = write_data;

    // NOTE: both outputs are assigned on every path through this block, so no latch is inferred.
    always_comb begin
        diff = (raw >= cfg_offset) ? ADC_BITS'(raw - cfg_offset) : '0;
        if (cfg_shift) begin
            reduced = OUT_BITS'(diff >> (ADC_BITS - OUT_BITS));
        end else if ((diff >> OUT_BITS) != '0) begin
            reduced = '1;
        end else begin
            reduced = diff[OUT_BITS-1:0];
        end
    end

    // NOTE: all state and outputs are flops updated with <=, so every output is registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cfg_count     <= '0;
            cfg_offset    <= '0;
            cfg_track     <= '0;
            cfg_shift     <= 1'b0;
            track_cnt     <= '0;
            pix_done      <= '0;
            write_enable  <= 1'b0;
            write_data    <= '0;
            pixel_advance <= 1'b0;
            capture_done  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (capture_start) begin
                        cfg_count  <= pixel_count;
                        cfg_offset <= val_offset;
                        cfg_track  <= track_counts;
                        cfg_shift  <= scale_mode;
                        pix_done   <= '0;
                        busy       <= 1'b1;
                        if (pixel_count == '0) begin
                            state        <= ST_DONE;
                            capture_done <= 1'b1;
                        end else begin
                            state     <= ST_TRACK;
                            track_cnt <= track_counts;
                        end
                    end
                end
                ST_TRACK: begin
                    if (track_cnt == '0) state <= ST_CONVERT;
                    else                 track_cnt <= track_cnt - 1'b1;
                end
                ST_CONVERT: begin
                    if (frame_done) begin
                        state         <= ST_WRITE;
                        write_data    <= reduced;
                        write_enable  <= !bus.fifo_full;
                        pixel_advance <= !bus.fifo_full;
                    end
                end
                ST_WRITE: begin
                    // The strobe for a WRITE cycle is decided by the full flag at the edge opening it.
                    if (write_enable) begin
                        write_enable  <= 1'b0;
                        pixel_advance <= 1'b0;
                        pix_done      <= PIX_W'(pix_done + 1'b1);
                        if (PIX_W'(pix_done + 1'b1) == cfg_count) begin
                            state        <= ST_DONE;
                            capture_done <= 1'b1;
                        end else begin
                            state     <= ST_TRACK;
                            track_cnt <= cfg_track;
                        end
                    end else begin
                        write_enable  <= !bus.fifo_full;
                        pixel_advance <= !bus.fifo_full;
                    end
                end
                ST_DONE: begin
                    capture_done <= 1'b0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_stream_controller.sv
// Scoreboard bench: captures are issued with expected FIFO words queued from an arithmetic model,
// while independent monitors check writes, done pulses and every cs_n/sclk frame.
module tb_adc_stream_controller;
    localparam int ADC_BITS    = 10;
    localparam int OUT_BITS    = 8;
    localparam int FRAME_SCLKS = 16;
    localparam int LEAD_ZEROS  = 3;
    localparam int SCLK_HALF   = 1;
    localparam int MAX_PIXELS  = 112;
    localparam int PIX_W       = $clog2(MAX_PIXELS + 1);
    localparam int CONV_CYCLES = 2 * SCLK_HALF * FRAME_SCLKS;
    localparam int STALL       = 20;

    typedef struct {
        logic [OUT_BITS-1:0] data;
        int                  cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                capture_start = 1'b0;
    logic [PIX_W-1:0]    pixel_count = '0;
    logic [ADC_BITS-1:0] val_offset = '0;
    logic [7:0]          track_counts = 8'd14;
    logic                scale_mode = 1'b0;
    logic                pixel_advance;
    logic                capture_done;
    logic                busy;

    adc_stream_controller_if #(.OUT_BITS(OUT_BITS)) bus ();

    adc_stream_controller #(
        .ADC_BITS   (ADC_BITS),
        .OUT_BITS   (OUT_BITS),
        .FRAME_SCLKS(FRAME_SCLKS),
        .LEAD_ZEROS (LEAD_ZEROS),
        .SCLK_HALF  (SCLK_HALF),
        .MAX_PIXELS (MAX_PIXELS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .capture_start(capture_start),
        .pixel_count  (pixel_count),
        .val_offset   (val_offset),
        .track_counts (track_counts),
        .scale_mode   (scale_mode),
        .pixel_advance(pixel_advance),
        .capture_done (capture_done),
        .busy         (busy),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_writes = 0;
    int   adv_cnt = 0;
    int   done_cnt = 0;
    int   windows = 0;
    int   exp_done_cyc = -1;
    bit   abort_window = 1'b0;
    exp_t exp_q[$];
    int   raw_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int ref_model(input int raw, input int off, input bit shift_mode);
        int d;
        d = raw - off;
        if (d < 0) d = 0;
        if (shift_mode) return d / (1 << (ADC_BITS - OUT_BITS));
        return (d > (1 << OUT_BITS) - 1) ? (1 << OUT_BITS) - 1 : d;
    endfunction

    // ADC model: result bits follow falling sclk edges LEAD_ZEROS+1..LEAD_ZEROS+ADC_BITS; elsewhere noise.
    int                  fall_idx = 0;
    logic [ADC_BITS-1:0] cur_raw = '0;
    initial begin
        bus.sdata = 1'b0;
        bus.fifo_full = 1'b0;
    end
    always @(negedge bus.cs_n) begin
        fall_idx = 0;
        cur_raw  = (raw_q.size() != 0) ? ADC_BITS'(raw_q.pop_front()) : '0;
    end
    always @(negedge bus.sclk) begin
        if (!bus.cs_n) begin
            fall_idx++;
            #1;
            if (fall_idx >= LEAD_ZEROS + 1 && fall_idx <= LEAD_ZEROS + ADC_BITS)
                bus.sdata = cur_raw[ADC_BITS - 1 - (fall_idx - LEAD_ZEROS - 1)];
            else
                bus.sdata = 1'($urandom_range(0, 1));
        end
    end

    // Write / done monitor.
    always @(negedge clk) begin
        exp_t e;
        if (bus.fifo_write_enable) begin
            n_writes++;
            check("adv_with_write", pixel_advance, 1);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_data", bus.fifo_write_data, e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
        if (pixel_advance) adv_cnt++;
        if (capture_done) begin
            done_cnt++;
            check("done_cycle", cyc, exp_done_cyc);
        end
    end

    // Frame monitor: cs_n low length and sclk rising edges per window.
    int low_cnt = 0;
    int rises = 0;
    logic prev_csn = 1'b1;
    logic prev_sclk = 1'b1;
    always @(negedge clk) begin
        if (!bus.cs_n) begin
            low_cnt++;
            if (!prev_sclk && bus.sclk) rises++;
        end else if (!prev_csn) begin
            if (!prev_sclk && bus.sclk) rises++;
            if (!abort_window) begin
                check("csn_low_cycles", low_cnt, CONV_CYCLES);
                check("sclk_rises", rises, FRAME_SCLKS);
            end
            abort_window = 1'b0;
            windows++;
        end
        if (bus.cs_n) begin
            low_cnt = 0;
            rises = 0;
        end
        prev_csn  = bus.cs_n;
        prev_sclk = bus.sclk;
    end

    task automatic run_capture(input int n, input int off, input bit mode, input int tc,
                               input int fixed_raw, input int stall_pix, input bit repulse);
        int k, per, stall, last_w, budget, e_cyc, w0, a0, d0, win0, raw;
        per = tc + 1 + CONV_CYCLES + 1;
        w0 = n_writes; a0 = adv_cnt; d0 = done_cnt; win0 = windows;
        @(negedge clk);
        pixel_count   = PIX_W'(n);
        val_offset    = ADC_BITS'(off);
        scale_mode    = mode;
        track_counts  = 8'(tc);
        capture_start = 1'b1;
        k = cyc + 1;
        stall = 0;
        last_w = k;
        for (int i = 0; i < n; i++) begin
            raw = (fixed_raw >= 0) ? fixed_raw : int'($urandom_range(0, (1 << ADC_BITS) - 1));
            raw_q.push_back(raw);
            if (i == stall_pix) stall = STALL;
            last_w = k + per * (i + 1) - 1 + stall;
            exp_q.push_back('{OUT_BITS'(ref_model(raw, off, mode)), last_w});
        end
        exp_done_cyc = (n == 0) ? k : last_w + 1;
        @(negedge clk);
        capture_start = 1'b0;
        fork
            begin
                if (stall_pix >= 0) begin
                    e_cyc = k + per * (stall_pix + 1) - 1;
                    while (cyc < e_cyc - 1) @(negedge clk);
                    bus.fifo_full = 1'b1;
                    while (cyc < e_cyc + STALL - 1) @(negedge clk);
                    bus.fifo_full = 1'b0;
                end
            end
            begin
                if (repulse) begin
                    repeat (30) @(negedge clk);
                    capture_start = 1'b1;
                    pixel_count   = PIX_W'(n + 2);
                    val_offset    = ~ADC_BITS'(off);
                    scale_mode    = ~mode;
                    track_counts  = 8'd0;
                    @(negedge clk);
                    capture_start = 1'b0;
                end
            end
        join
        budget = n * (per + STALL + 10) + 20;
        while (!capture_done && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!capture_done) begin
            check("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            check("busy_drop", busy, 0);
            check("done_pulses", done_cnt - d0, 1);
        end
        check("writes", n_writes - w0, n);
        check("advances", adv_cnt - a0, n);
        check("csn_windows", windows - win0, n);
        check("exp_left", exp_q.size(), 0);
        exp_q.delete();
        raw_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_mid_convert();
        int k, per, w0, d0, raw;
        per = 14 + 1 + CONV_CYCLES + 1;
        d0 = done_cnt;
        @(negedge clk);
        pixel_count   = PIX_W'(3);
        val_offset    = ADC_BITS'($urandom_range(0, 63));
        scale_mode    = 1'($urandom_range(0, 1));
        track_counts  = 8'd14;
        capture_start = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            raw = int'($urandom_range(0, (1 << ADC_BITS) - 1));
            raw_q.push_back(raw);
            if (i == 0)
                exp_q.push_back('{OUT_BITS'(ref_model(raw, int'(val_offset), scale_mode)), k + per - 1});
        end
        exp_done_cyc = -1;
        @(negedge clk);
        capture_start = 1'b0;
        while (cyc < k + per + 14 + 12) @(negedge clk);
        check("pre_reset_csn", bus.cs_n, 0);
        w0 = n_writes;
        abort_window = 1'b1;
        #3;
        reset_n = 1'b0;
        raw_q.delete();
        #1;
        check("rst_csn_async", bus.cs_n, 1);
        check("rst_sclk_async", bus.sclk, 1);
        check("rst_busy_async", busy, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_no_write", n_writes - w0, 0);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_exp_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, stall_pix;
        repeat (2) @(negedge clk);
        check("reset_csn", bus.cs_n, 1);
        check("reset_sclk", bus.sclk, 1);
        check("reset_we", bus.fifo_write_enable, 0);
        check("reset_data", bus.fifo_write_data, 0);
        check("reset_adv", pixel_advance, 0);
        check("reset_done", capture_done, 0);
        check("reset_busy", busy, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_capture(3, 1, 1'b1, 14, 'h2A5, -1, 1'b0);
        run_capture(3, 1, 1'b0, 14, 'h2A5, -1, 1'b0);
        run_capture(2, 'h10, 1'b0, 14, 'h005, -1, 1'b0);
        run_capture(2, 'h10, 1'b1, 14, 'h005, -1, 1'b0);
        run_capture(3, 1, 1'b1, 14, 'h2A5, 1, 1'b0);
        run_capture(0, 0, 1'b0, 14, -1, -1, 1'b0);
        run_capture(4, int'($urandom_range(0, 200)), 1'($urandom_range(0, 1)), 14, -1, -1, 1'b1);

        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, 5));
            stall_pix = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_capture(n, int'($urandom_range(0, 300)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 20)), -1, stall_pix, 1'b0);
        end

        reset_mid_convert();
        run_capture(3, int'($urandom_range(0, 100)), 1'($urandom_range(0, 1)), 14, -1, -1, 1'b0);

        run_capture(MAX_PIXELS, int'($urandom_range(0, 100)), 1'($urandom_range(0, 1)), 0, -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_stream_controller.md
# adc_stream_controller

Parametrised successor to the single-mode Stonyman pixel ADC reader. It drives a TI ADCxx1S101-family serial ADC (cs_n/sclk/sdata) through a run-time count of pixel conversions. For each pixel it subtracts a black-level offset, reduces the result to the output width by clamp or shift, and writes one byte per pixel to the downstream FIFO with full-flag back-pressure. It sits between the Stonyman sequencer, which advances the pixel on `pixel_advance`, and the frame FIFO.

## Interface
- `ADC_BITS`, 10: ADC result width (8/10/12 for 081/101/121 parts).
- `OUT_BITS`, 8: FIFO data width; must be ≤ ADC_BITS.
- `FRAME_SCLKS`, 16: sclk periods per conversion frame.
- `LEAD_ZEROS`, 3: sclk periods before the result MSB; LEAD_ZEROS+ADC_BITS ≤ FRAME_SCLKS.
- `SCLK_HALF`, 1: clk cycles per sclk half-period (sclk = clk/(2·SCLK_HALF)).
- `MAX_PIXELS`, 112: upper bound for `pixel_count`. `PIX_W` = clog2(MAX_PIXELS+1).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `capture_start`  in  1  single-cycle start request; honoured only in IDLE.
- `pixel_count`  in  PIX_W  conversions per capture; sampled at start.
- `val_offset`  in  ADC_BITS  black-level offset; sampled at start.
- `track_counts`  in  8  settle cycles before each conversion; sampled at start.
- `scale_mode`  in  1  0 = clamp, 1 = shift right by ADC_BITS−OUT_BITS; sampled at start.
- `fifo_full`  in  1  downstream FIFO full.
- `sdata`  in  1  ADC serial data.
- `sclk`  out  1  ADC serial clock; idles high.
- `cs_n`  out  1  ADC chip select, active low.
- `fifo_write_enable`  out  1  one-cycle write strobe.
- `fifo_write_data`  out  OUT_BITS  pixel value.
- `pixel_advance`  out  1  one-cycle pulse; the sequencer steps to the next pixel.
- `capture_done`  out  1  one-cycle pulse at the end of a capture.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States are IDLE → TRACK → CONVERT → WRITE → (TRACK | DONE) → IDLE.
- IDLE: when `capture_start` is high, latch the config, clear the pixel counter and go to TRACK. If `pixel_count` is 0, go to DONE instead.
- TRACK: lasts exactly `track_counts`+1 cycles, with cs_n high and sclk high.
- CONVERT: cs_n is low for exactly 2·SCLK_HALF·FRAME_SCLKS cycles.
  - sclk falls SCLK_HALF cycles after cs_n falls.
  - sdata is sampled on the clk edge where sclk rises.
  - Rising edges LEAD_ZEROS+1 … LEAD_ZEROS+ADC_BITS shift in the result, MSB first. All other bits are ignored.
- WRITE: the reduced value is registered on entry.
  - Each cycle with `fifo_full`=0 asserts `fifo_write_enable` and `pixel_advance` together.
  - Then: if pixels done = `pixel_count`, go to DONE; otherwise go to TRACK.
  - While `fifo_full`=1 the block stalls in WRITE. No sample is lost or duplicated.
- DONE: `capture_done` is high for one cycle, then the block returns to IDLE.
- Arithmetic:
  - d = raw − offset, saturated at 0. There is no wrap.
  - Clamp mode: out = min(d, 2^OUT_BITS−1).
  - Shift mode: out = d >> (ADC_BITS−OUT_BITS).
- `capture_start` asserted while busy is ignored. It is not queued.
- Config input changes mid-capture have no effect.

## Timing
- Reset values: cs_n=1, sclk=1, fifo_write_enable=0, fifo_write_data=0, pixel_advance=0, capture_done=0, busy=0, state IDLE.
- Reset asserted mid-conversion: cs_n and sclk go high immediately (asynchronously). No write is issued, and no `capture_done` pulse is issued.
- All outputs are registered. There are no combinational paths from input to output.
- Per pixel, without stall: `track_counts` + 1 + 2·SCLK_HALF·FRAME_SCLKS + 1 cycles. Defaults with track_counts=14 give 48 cycles.
- `capture_start` at edge k → busy=1 and TRACK from k+1. The first cs_n fall is at k+track_counts+2.
- `capture_done` pulses on the cycle after the last write. `busy` drops on the following cycle.
- pixel_count=0: `capture_done` pulses at k+1, and cs_n never falls.

## Structure
- Shared package `stonyman_adc_pkg` holds:
  - the state enum;
  - default parameter constants (ADC_BITS, FRAME_SCLKS, LEAD_ZEROS, MAX_PIXELS);
  - the ADC part-width constants (8/10/12).
- One sub-module, `adc_serial_frame`, generates cs_n/sclk, holds the shift register and produces a `frame_done` pulse with the raw result.
- The top level holds the FSM, the counters and the offset/scale datapath.

## Test plan
All scenarios use defaults with track_counts=14, unless stated otherwise.

- ADC model returns 0x2A5, offset=1, scale_mode=1, pixel_count=3 → three writes of 0xA9, 48 cycles apart; three `pixel_advance` pulses; one `capture_done`.
- Same input, scale_mode=0 → data 0xFF (clamp). With raw 0x005 and offset 0x010 → data 0x00 (saturation).
- `fifo_full` held high for 20 cycles during the second WRITE → the write is delayed by exactly 20 cycles, the data is unchanged, and the total write count is 3.
- pixel_count=0 → `capture_done` at k+1, cs_n stays 1, no writes.
- `reset_n` pulsed low mid-CONVERT of pixel 2 → cs_n and sclk go high in the same cycle, there is no write or done, and a new `capture_start` after release runs a full capture.
- `capture_start` re-pulsed while busy → ignored; exactly `pixel_count` writes occur; sclk count per cs_n-low window = 16.
